// File: rtl/csr_trap_sequencer.sv
// Shares the single machine-mode CSR file port between core CSR accesses, the trap-entry
// sequence and MRET, and issues a one-cycle PC redirect at the end of each sequence.
module csr_trap_sequencer #(
  parameter int unsigned CSR_AW = 12,
  parameter int unsigned XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              core_req_i,
  input  logic              core_we_i,
  input  logic [CSR_AW-1:0] core_addr_i,
  input  logic [XLEN-1:0]   core_wdata_i,
  output logic              core_gnt_o,
  output logic              core_rvalid_o,
  output logic [XLEN-1:0]   core_rdata_o,
  input  logic              trap_req_i,
  input  logic [XLEN-1:0]   trap_cause_i,
  input  logic [XLEN-1:0]   trap_pc_i,
  output logic              trap_ack_o,
  input  logic              mret_req_i,
  output logic              mret_ack_o,
  output logic              redirect_valid_o,
  output logic [XLEN-1:0]   redirect_pc_o,
  output logic              busy_o,
  output logic [CSR_AW-1:0] csr_addr_o,
  output logic              csr_we_o,
  output logic              csr_re_o,
  output logic [XLEN-1:0]   csr_wdata_o,
  input  logic [XLEN-1:0]   csr_rdata_i
);

  localparam logic [CSR_AW-1:0] AddrMstatus = CSR_AW'(12'h300);
  localparam logic [CSR_AW-1:0] AddrMtvec   = CSR_AW'(12'h305);
  localparam logic [CSR_AW-1:0] AddrMepc    = CSR_AW'(12'h341);
  localparam logic [CSR_AW-1:0] AddrMcause  = CSR_AW'(12'h342);

  typedef enum logic [3:0] {
    StIdle, StCRd,
    StTEpc, StTCause, StTRdSt, StTWrSt, StTRdVec, StTVec,
    StRRdSt, StRWrSt, StRRdEpc, StREpc
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic            redir_valid_q, redir_valid_d;

  logic            idle;
  logic [XLEN-1:0] vec_base, vec_pc, trap_mstatus, mret_mstatus;

  assign idle       = (state_q == StIdle);
  assign trap_ack_o = idle & trap_req_i;
  assign mret_ack_o = idle & mret_req_i & ~trap_req_i;
  assign core_gnt_o = idle & core_req_i & ~trap_req_i & ~mret_req_i;

  // Vectored mode only applies to interrupts; the offset shift wraps at XLEN bits.
  assign vec_base = {csr_rdata_i[XLEN-1:2], 2'b00};
  assign vec_pc   = (csr_rdata_i[1:0] == 2'b01 && cause_q[XLEN-1])
                    ? vec_base + {cause_q[XLEN-3:0], 2'b00} : vec_base;

  always_comb begin
    trap_mstatus         = csr_rdata_i;
    trap_mstatus[7]      = csr_rdata_i[3];
    trap_mstatus[3]      = 1'b0;
    trap_mstatus[12:11]  = 2'b11;
    mret_mstatus         = csr_rdata_i;
    mret_mstatus[3]      = csr_rdata_i[7];
    mret_mstatus[7]      = 1'b1;
    mret_mstatus[12:11]  = 2'b11;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      cause_q       <= '0;
      pc_q          <= '0;
      redir_pc_q    <= '0;
      redir_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cause_q       <= cause_d;
      pc_q          <= pc_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cause_d       = cause_q;
    pc_d          = pc_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (trap_req_i) begin
          state_d = StTEpc;
          cause_d = trap_cause_i;
          pc_d    = trap_pc_i;
        end else if (mret_req_i) begin
          state_d = StRRdSt;
        end else if (core_req_i && !core_we_i) begin
          state_d = StCRd;
        end
      end
      StCRd:    state_d = StIdle;
      StTEpc:   state_d = StTCause;
      StTCause: state_d = StTRdSt;
      StTRdSt:  state_d = StTWrSt;
      StTWrSt:  state_d = StTRdVec;
      StTRdVec: state_d = StTVec;
      StTVec: begin
        redir_pc_d    = vec_pc;
        redir_valid_d = 1'b1;
        state_d       = StIdle;
      end
      StRRdSt:  state_d = StRWrSt;
      StRWrSt:  state_d = StRRdEpc;
      StRRdEpc: state_d = StREpc;
      StREpc: begin
        redir_pc_d    = {csr_rdata_i[XLEN-1:2], 2'b00};
        redir_valid_d = 1'b1;
        state_d       = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    csr_addr_o  = '0;
    csr_we_o    = 1'b0;
    csr_re_o    = 1'b0;
    csr_wdata_o = '0;
    case (state_q)
      StIdle: begin
        if (core_gnt_o) begin
          csr_addr_o  = core_addr_i;
          csr_we_o    = core_we_i;
          csr_re_o    = ~core_we_i;
          csr_wdata_o = core_wdata_i;
        end
      end
      StTEpc: begin
        csr_addr_o  = AddrMepc;
        csr_we_o    = 1'b1;
        csr_wdata_o = {pc_q[XLEN-1:2], 2'b00};
      end
      StTCause: begin
        csr_addr_o  = AddrMcause;
        csr_we_o    = 1'b1;
        csr_wdata_o = cause_q;
      end
      StTRdSt, StRRdSt: begin
        csr_addr_o = AddrMstatus;
        csr_re_o   = 1'b1;
      end
      StTWrSt: begin
        csr_addr_o  = AddrMstatus;
        csr_we_o    = 1'b1;
        csr_wdata_o = trap_mstatus;
      end
      StRWrSt: begin
        csr_addr_o  = AddrMstatus;
        csr_we_o    = 1'b1;
        csr_wdata_o = mret_mstatus;
      end
      StTRdVec: begin
        csr_addr_o = AddrMtvec;
        csr_re_o   = 1'b1;
      end
      StRRdEpc: begin
        csr_addr_o = AddrMepc;
        csr_re_o   = 1'b1;
      end
      default: ;
    endcase
  end

  assign core_rvalid_o    = (state_q == StCRd);
  assign core_rdata_o     = core_rvalid_o ? csr_rdata_i : '0;
  assign redirect_valid_o = redir_valid_q;
  assign redirect_pc_o    = redir_pc_q;
  assign busy_o           = ~idle;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Randomized scoreboard bench for csr_trap_sequencer with a behavioural CSR-state reference model
// and a simple registered-read CSR file.
module tb_csr_trap_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [11:0] core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_rvalid;
  logic [31:0] core_rdata;
  logic        trap_req = 1'b0;
  logic [31:0] trap_cause = '0, trap_pc = '0;
  logic        trap_ack, mret_req = 1'b0, mret_ack;
  logic        redirect_valid, busy;
  logic [31:0] redirect_pc;
  logic [11:0] csr_addr;
  logic        csr_we, csr_re;
  logic [31:0] csr_wdata, csr_rdata;

  always #5 clk = ~clk;

  csr_trap_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_addr_i(core_addr),
    .core_wdata_i(core_wdata), .core_gnt_o(core_gnt), .core_rvalid_o(core_rvalid),
    .core_rdata_o(core_rdata),
    .trap_req_i(trap_req), .trap_cause_i(trap_cause), .trap_pc_i(trap_pc), .trap_ack_o(trap_ack),
    .mret_req_i(mret_req), .mret_ack_o(mret_ack),
    .redirect_valid_o(redirect_valid), .redirect_pc_o(redirect_pc), .busy_o(busy),
    .csr_addr_o(csr_addr), .csr_we_o(csr_we), .csr_re_o(csr_re), .csr_wdata_o(csr_wdata),
    .csr_rdata_i(csr_rdata)
  );

  // CSR file: write on the clock, read data registered one cycle after the read enable.
  logic [31:0] mem [0:4095];
  always @(posedge clk) begin
    if (csr_we) mem[csr_addr] <= csr_wdata;
    if (csr_re) csr_rdata <= mem[csr_addr];
  end

  logic [31:0] ref_csr [0:4095];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_redir;
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] trap_ms(logic [31:0] m);
    return (m & ~32'h1888) | (m[3] ? 32'h80 : 32'h0) | 32'h1800;
  endfunction

  function automatic logic [31:0] mret_ms(logic [31:0] m);
    return (m & ~32'h8) | (m[7] ? 32'h8 : 32'h0) | 32'h1880;
  endfunction

  function automatic logic [31:0] vec_pc(logic [31:0] mtvec, logic [31:0] cause);
    logic [31:0] base;
    base = mtvec & 32'hFFFF_FFFC;
    if (mtvec % 4 == 1 && cause >= 32'h8000_0000) return base + (cause - 32'h8000_0000) * 4;
    return base;
  endfunction

  function automatic logic [11:0] pick_addr(int k);
    case (k)
      0: return 12'h300;
      1: return 12'h304;
      2: return 12'h305;
      3: return 12'h341;
      4: return 12'h342;
      default: return 12'h340;
    endcase
  endfunction

  // Monitor: pops an expectation whenever the DUT presents a read response or a redirect.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("we_re_exclusive", {31'b0, csr_we & csr_re}, 32'h0);
      if (core_rvalid || redirect_valid) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_response: rvalid=%0b redirect=%0b, expected none",
                   core_rvalid, redirect_valid);
        end else begin
          e_m = q.pop_front();
          chk("resp_kind", {31'b0, redirect_valid}, {31'b0, e_m.is_redir});
          chk("resp_data", redirect_valid ? redirect_pc : core_rdata, e_m.val);
          chk("resp_cycle", 32'(cyc), 32'(e_m.cyc));
        end
      end else if (q.size() > 0 && q[0].cyc < cyc) begin
        e_m = q.pop_front();
        chk("resp_missing", 32'h0, e_m.val);
        n_cmp++;
        if (e_m.val == 32'h0) begin
          n_bad++;
          $display("FAIL resp_missing: no response, expected one at cycle %0d", e_m.cyc);
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_pending", 32'(q.size()), 32'h0);
    q.delete();
  endtask

  task automatic do_core(bit we, logic [11:0] a, logic [31:0] d);
    int lat = -1;
    @(posedge clk); #1;
    core_req = 1'b1; core_we = we; core_addr = a; core_wdata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (core_gnt) begin lat = i; break; end
    end
    chk("core_gnt_latency", 32'(lat), 32'h0);
    if (lat >= 0) begin
      if (we) ref_csr[a] = d;
      else q.push_back('{1'b0, ref_csr[a], cyc + 1});
    end
    @(posedge clk); #1;
    core_req = 1'b0; core_we = 1'b0;
    drain();
  endtask

  task automatic check_csrs();
    chk("csr_mstatus", mem[12'h300], ref_csr[12'h300]);
    chk("csr_mepc", mem[12'h341], ref_csr[12'h341]);
    chk("csr_mcause", mem[12'h342], ref_csr[12'h342]);
  endtask

  task automatic do_trap(logic [31:0] cause, logic [31:0] pc);
    int lat = -1;
    @(posedge clk); #1;
    trap_req = 1'b1; trap_cause = cause; trap_pc = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trap_ack) begin lat = i; break; end
    end
    chk("trap_ack_latency", 32'(lat), 32'h0);
    if (lat >= 0) begin
      ref_csr[12'h341] = pc & ~32'h3;
      ref_csr[12'h342] = cause;
      ref_csr[12'h300] = trap_ms(ref_csr[12'h300]);
      q.push_back('{1'b1, vec_pc(ref_csr[12'h305], cause), cyc + 7});
    end
    @(posedge clk); #1;
    trap_req = 1'b0;
    drain();
    check_csrs();
  endtask

  task automatic do_mret();
    int lat = -1;
    @(posedge clk); #1;
    mret_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mret_ack) begin lat = i; break; end
    end
    chk("mret_ack_latency", 32'(lat), 32'h0);
    if (lat >= 0) begin
      ref_csr[12'h300] = mret_ms(ref_csr[12'h300]);
      q.push_back('{1'b1, ref_csr[12'h341] & ~32'h3, cyc + 5});
    end
    @(posedge clk); #1;
    mret_req = 1'b0;
    drain();
    check_csrs();
  endtask

  task automatic do_arb();
    int t0 = -1, m0 = -1, g0 = -1, s0;
    @(posedge clk); #1;
    trap_req = 1'b1; trap_cause = 32'h8000_0003; trap_pc = 32'h0000_4444;
    mret_req = 1'b1;
    core_req = 1'b1; core_we = 1'b0; core_addr = 12'h300;
    s0 = cyc;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("arb_single_grant", {31'b0, (32'(trap_ack) + 32'(mret_ack) + 32'(core_gnt)) > 1},
          32'h0);
      if (trap_ack) begin
        t0 = cyc;
        ref_csr[12'h341] = trap_pc & ~32'h3;
        ref_csr[12'h342] = trap_cause;
        ref_csr[12'h300] = trap_ms(ref_csr[12'h300]);
        q.push_back('{1'b1, vec_pc(ref_csr[12'h305], trap_cause), cyc + 7});
      end
      if (mret_ack) begin
        m0 = cyc;
        ref_csr[12'h300] = mret_ms(ref_csr[12'h300]);
        q.push_back('{1'b1, ref_csr[12'h341] & ~32'h3, cyc + 5});
      end
      if (core_gnt) begin
        g0 = cyc;
        q.push_back('{1'b0, ref_csr[12'h300], cyc + 1});
      end
      @(posedge clk); #1;
      if (t0 >= 0) trap_req = 1'b0;
      if (m0 >= 0) mret_req = 1'b0;
      if (g0 >= 0) begin core_req = 1'b0; break; end
    end
    chk("arb_trap_first", 32'(t0 - s0), 32'h0);
    chk("arb_mret_c7", 32'(m0 - t0), 32'd7);
    chk("arb_core_c12", 32'(g0 - t0), 32'd12);
    trap_req = 1'b0; mret_req = 1'b0; core_req = 1'b0;
    drain();
    check_csrs();
  endtask

  task automatic do_reset_midtrap();
    int t0 = -1;
    logic [31:0] ms_before;
    ms_before = ref_csr[12'h300];
    @(posedge clk); #1;
    trap_req = 1'b1; trap_cause = 32'h0000_0005; trap_pc = 32'h0000_0AA8;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (trap_ack) begin t0 = cyc; break; end
    end
    chk("rst_trap_ack", {31'b0, t0 >= 0}, 32'h1);
    ref_csr[12'h341] = 32'h0000_0AA8;
    ref_csr[12'h342] = 32'h0000_0005;
    @(posedge clk); #1;
    trap_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (cyc >= t0 + 4) break;
      @(negedge clk);
    end
    chk("rst_in_wrst_we", {31'b0, csr_we}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk("rst_core_rdata", core_rdata, 32'h0);
    chk("rst_csr_we_re", {30'b0, csr_we, csr_re}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    chk("post_rst_mstatus_kept", mem[12'h300], ms_before);
    check_csrs();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'h0;
      ref_csr[i] = 32'h0;
    end
    csr_rdata = 32'h0;
    #2;
    chk("reset_busy", {31'b0, busy}, 32'h0);
    chk("reset_redirect_valid", {31'b0, redirect_valid}, 32'h0);
    chk("reset_redirect_pc", redirect_pc, 32'h0);
    chk("reset_rvalid_rdata", {31'b0, core_rvalid} | core_rdata, 32'h0);
    chk("reset_acks", {30'b0, trap_ack, mret_ack}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    do_core(1'b1, 12'h304, 32'h888);
    do_core(1'b0, 12'h304, 32'h0);
    do_core(1'b1, 12'h305, 32'h8000_0001);
    do_trap(32'h8000_0007, 32'h0000_0100);
    chk("t2_mepc", mem[12'h341], 32'h0000_0100);
    chk("t2_mcause", mem[12'h342], 32'h8000_0007);
    do_core(1'b1, 12'h300, 32'h8);
    do_trap(32'h0000_0002, 32'h0000_0104);
    chk("t3_mstatus", mem[12'h300], 32'h1880);
    do_core(1'b1, 12'h341, 32'h203);
    do_mret();
    chk("t4_mstatus", mem[12'h300], 32'h1888);
    do_arb();
    do_reset_midtrap();
    do_trap(32'h8000_0001, 32'h0000_0300);

    for (int n = 0; n < 200; n++) begin
      int r;
      logic [31:0] c;
      r = $urandom_range(0, 9);
      if (r < 3) begin
        do_core(1'b1, pick_addr($urandom_range(0, 5)), $urandom);
      end else if (r < 6) begin
        do_core(1'b0, pick_addr($urandom_range(0, 5)), 32'h0);
      end else if (r < 8) begin
        c = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 15));
        c[31] = 1'($urandom_range(0, 1));
        do_trap(c, $urandom);
      end else begin
        do_mret();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
